jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller and instruction register. Sits directly upstream of the TAP instruction-decode/TDO-select logic.
- Inputs: TMS/TDI pad signals. Outputs to the decode stage:
  - DR-phase strobes: test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o.
  - The current instruction.
- Drives the TDO pad from three sources: IR shift data, the decode stage's next_tdo, or an internal 1-bit bypass register.

Parameters:
- INST_LENGTH, 4, instruction register width.
- INST_RESET, 4'b1111, instruction loaded in Test-Logic-Reset. Equals BYPASS.
- INST_RETURN, 4'b1101, value captured into the IR shifter in Capture-IR. Bits [1:0] must be 2'b01.
- BYPASS, 4'b1111, opcode that routes the bypass register to TDO.

Ports:
- clk  in  1  TCK-domain clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- tms_pad_in  in  1  test mode select.
- tdi_pad_in  in  1  test data in.
- next_tdo  in  1  DR serial data from the decode stage.
- tdo_pad_out  out  1  registered TDO.
- tdo_pad_oe  out  1  TDO output enable.
- instruction  out  INST_LENGTH  active instruction.
- tap_state  out  4  current FSM state code.
- test_logic_reset_o  out  1  high in Test-Logic-Reset.
- capture_dr_o  out  1  high in Capture-DR.
- shift_dr_o  out  1  high in Shift-DR.
- update_dr_o  out  1  high in Update-DR.
- shift_ir_o  out  1  high in Shift-IR.

Behaviour:

State codes (4-bit):
- TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5.
- SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.

Transitions, evaluated on each clk edge, written as tms=0 / tms=1:
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- CAP_DR: SH_DR / EX1_DR
- SH_DR: SH_DR / EX1_DR
- EX1_DR: PAU_DR / UPD_DR
- PAU_DR: PAU_DR / EX2_DR
- EX2_DR: SH_DR / UPD_DR
- UPD_DR: RTI / SEL_DR
- SEL_IR: CAP_IR / TLR
- IR branch (CAP_IR through UPD_IR) mirrors the DR branch.
- Holding tms=1 for 5 edges reaches TLR from any state.

Reset:
- reset=1 at an edge forces, regardless of TMS or the current state (including mid-shift):
  - state=TLR
  - instruction=INST_RESET
  - IR shifter=INST_RETURN
  - bypass=0
  - tdo_pad_out=0
  - tdo_pad_oe=0

Strobes:
- tap_state, test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o and shift_ir_o are combinational decodes of the current state.
- Each strobe is high for exactly the cycles spent in its state.

IR shifter (edge actions by current state):
- CAP_IR: load INST_RETURN.
- SH_IR: shift right, {tdi_pad_in, ir[L-1:1]}.
- UPD_IR: instruction <= shifter.
- TLR: instruction <= INST_RESET.
- Otherwise: hold. Pause states and Exit states hold both the shifter and the instruction.

Bypass register (edge actions):
- CAP_DR: load 0.
- SH_DR: load tdi_pad_in.
- Otherwise: hold.

TDO (registered, updated on every edge):
- In SH_IR: tdo_pad_out <= ir[0], tdo_pad_oe <= 1.
- In SH_DR: tdo_pad_out <= (instruction==BYPASS ? bypass : next_tdo), tdo_pad_oe <= 1.
- Otherwise: tdo_pad_out <= 0, tdo_pad_oe <= 0.
- The value driven is the pre-shift value; the pad lags the shift by one clk.

Instruction changes only in UPD_IR and TLR. It is never disturbed by DR scans or pause states.

Test Plan:
- Reset held 1 for 2 edges, tms=0 → tap_state=F, test_logic_reset_o=1, instruction=4'b1111, tdo_pad_oe=0. Release reset with tms=0 → next state C.
- From SH_DR, apply tms=1 for 5 edges → sequence 1,5,7,4,F; instruction=4'b1111 and test_logic_reset_o=1 at the end.
- IR scan:
  - Stimulus: tms 0,1,1,0,0 to reach SH_IR, then shift tdi = 1,1,0,0 (LSB first). The 4th bit is shifted with tms=1 into EX1_IR, then tms=1 → UPD_IR, then tms=0.
  - Required response: tdo_pad_out, one clk behind the shift, reads 1,0,1,1 (the LSB-first shift-out of INST_RETURN=4'b1101); instruction=4'b0011 after the UPD_IR edge; shift_ir_o high for exactly 4 cycles.
- DR scan, instruction=4'b0011, next_tdo driven 1,0,0,1:
  - capture_dr_o high for exactly 1 cycle.
  - shift_dr_o high for 4 cycles.
  - tdo_pad_out = 1,0,0,1 lagging by one clk.
  - update_dr_o high for 1 cycle.
  - instruction unchanged.
- Bypass, instruction=4'b1111, DR shift tdi = 1,0,1 → tdo_pad_out = 0,1,0 (captured 0 first, then tdi delayed by one bit); next_tdo ignored.
- Assert reset while in SH_IR midway through shifting 4'b0000 → state=F, instruction=4'b1111. A following full IR scan returns 1,0,1,1 on tdo.

Source files
------------

// File: rtl/jtag_tap_ctrl_if.sv
// Pad-side and decode-side signals of the JTAG TAP controller.
// The slave modport is the TAP controller's view; master is the environment driving the pads.
interface jtag_tap_ctrl_if #(
    parameter int INST_LENGTH = 4
);
    logic                   tms_pad_in;
    logic                   tdi_pad_in;
    logic                   next_tdo;
    logic                   tdo_pad_out;
    logic                   tdo_pad_oe;
    logic [INST_LENGTH-1:0] instruction;
    logic [3:0]             tap_state;
    logic                   test_logic_reset_o;
    logic                   capture_dr_o;
    logic                   shift_dr_o;
    logic                   update_dr_o;
    logic                   shift_ir_o;

    modport slave (
        input  tms_pad_in, tdi_pad_in, next_tdo,
        output tdo_pad_out, tdo_pad_oe, instruction, tap_state,
               test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o, shift_ir_o
    );

    modport master (
        output tms_pad_in, tdi_pad_in, next_tdo,
        input  tdo_pad_out, tdo_pad_oe, instruction, tap_state,
               test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o, shift_ir_o
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP state machine with instruction register, bypass register and
// registered TDO mux feeding the downstream instruction-decode stage.
module jtag_tap_ctrl #(
    parameter int                     INST_LENGTH = 4,
    parameter logic [INST_LENGTH-1:0] INST_RESET  = 4'b1111,
    parameter logic [INST_LENGTH-1:0] INST_RETURN = 4'b1101,
    parameter logic [INST_LENGTH-1:0] BYPASS      = 4'b1111
) (
    input  logic           clk,
    input  logic           reset,
    jtag_tap_ctrl_if.slave tap
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e             state_q, state_d;
    logic [INST_LENGTH-1:0] ir_shift_q, ir_shift_d;
    logic [INST_LENGTH-1:0] instruction_q, instruction_d;
    logic                   bypass_q, bypass_d;
    logic                   tdo_q, tdo_d;
    logic                   tdo_oe_q, tdo_oe_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= TLR;
            ir_shift_q    <= INST_RETURN;
            instruction_q <= INST_RESET;
            bypass_q      <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_shift_q    <= ir_shift_d;
            instruction_q <= instruction_d;
            bypass_q      <= bypass_d;
            tdo_q         <= tdo_d;
            tdo_oe_q      <= tdo_oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tap.tms_pad_in ? TLR    : RTI;
            RTI:    state_d = tap.tms_pad_in ? SEL_DR : RTI;
            SEL_DR: state_d = tap.tms_pad_in ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tap.tms_pad_in ? EX1_DR : SH_DR;
            SH_DR:  state_d = tap.tms_pad_in ? EX1_DR : SH_DR;
            EX1_DR: state_d = tap.tms_pad_in ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tap.tms_pad_in ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tap.tms_pad_in ? UPD_DR : SH_DR;
            UPD_DR: state_d = tap.tms_pad_in ? SEL_DR : RTI;
            SEL_IR: state_d = tap.tms_pad_in ? TLR    : CAP_IR;
            CAP_IR: state_d = tap.tms_pad_in ? EX1_IR : SH_IR;
            SH_IR:  state_d = tap.tms_pad_in ? EX1_IR : SH_IR;
            EX1_IR: state_d = tap.tms_pad_in ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tap.tms_pad_in ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tap.tms_pad_in ? UPD_IR : SH_IR;
            UPD_IR: state_d = tap.tms_pad_in ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Register datapath; TDO always presents the pre-shift bit of whichever chain is selected.
    always_comb begin
        ir_shift_d    = ir_shift_q;
        instruction_d = instruction_q;
        bypass_d      = bypass_q;
        tdo_d         = 1'b0;
        tdo_oe_d      = 1'b0;
        case (state_q)
            TLR: instruction_d = INST_RESET;
            CAP_IR: ir_shift_d = INST_RETURN;
            SH_IR: begin
                ir_shift_d = {tap.tdi_pad_in, ir_shift_q[INST_LENGTH-1:1]};
                tdo_d      = ir_shift_q[0];
                tdo_oe_d   = 1'b1;
            end
            UPD_IR: instruction_d = ir_shift_q;
            CAP_DR: bypass_d = 1'b0;
            SH_DR: begin
                bypass_d = tap.tdi_pad_in;
                tdo_d    = (instruction_q == BYPASS) ? bypass_q : tap.next_tdo;
                tdo_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign tap.tdo_pad_out        = tdo_q;
    assign tap.tdo_pad_oe         = tdo_oe_q;
    assign tap.instruction        = instruction_q;
    assign tap.tap_state          = state_q;
    assign tap.test_logic_reset_o = (state_q == TLR);
    assign tap.capture_dr_o       = (state_q == CAP_DR);
    assign tap.shift_dr_o         = (state_q == SH_DR);
    assign tap.update_dr_o        = (state_q == UPD_DR);
    assign tap.shift_ir_o         = (state_q == SH_IR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: expected TDO bits are queued as each shift is driven
// and popped after the clock edge that should present them on the pad.
module tb_jtag_tap_ctrl;

    localparam logic [3:0] INST_RETURN = 4'b1101;
    localparam logic [3:0] INST_RESET  = 4'b1111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jtag_tap_ctrl_if #(.INST_LENGTH(4)) bus ();

    jtag_tap_ctrl #(
        .INST_LENGTH(4),
        .INST_RESET (4'b1111),
        .INST_RETURN(4'b1101),
        .BYPASS     (4'b1111)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tap  (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic  exp_q[$];
    string tag_q[$];
    int shir_cnt, cap_cnt, shdr_cnt, upd_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive pads, let the edge happen, sample 1 ns later, retire any queued TDO bit.
    task automatic tick(input logic tms, input logic tdi, input logic nt);
        logic  e;
        string t;
        bus.tms_pad_in = tms;
        bus.tdi_pad_in = tdi;
        bus.next_tdo   = nt;
        @(posedge clk);
        #1;
        if (bus.shift_ir_o)   shir_cnt++;
        if (bus.capture_dr_o) cap_cnt++;
        if (bus.shift_dr_o)   shdr_cnt++;
        if (bus.update_dr_o)  upd_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_tdo"}, {31'b0, bus.tdo_pad_out}, {31'b0, e});
            chk({t, "_oe"},  {31'b0, bus.tdo_pad_oe},  32'd1);
        end
    endtask

    task automatic shift(input logic tms, input logic tdi, input logic nt,
                         input logic exp_tdo, input string tag);
        exp_q.push_back(exp_tdo);
        tag_q.push_back(tag);
        tick(tms, tdi, nt);
    endtask

    function automatic void clr_cnt();
        shir_cnt = 0; cap_cnt = 0; shdr_cnt = 0; upd_cnt = 0;
    endfunction

    // Full IR scan from Run-Test/Idle, ending back in Run-Test/Idle.
    task automatic ir_scan(input logic [3:0] val, input string tag);
        clr_cnt();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk({tag, "_state_shir"}, {28'b0, bus.tap_state}, 32'hA);
        for (int i = 0; i < 4; i++)
            shift(i == 3, val[i], 1'b0, INST_RETURN[i], $sformatf("%s_ir%0d", tag, i));
        chk({tag, "_state_ex1ir"}, {28'b0, bus.tap_state}, 32'h9);
        tick(1'b1, 1'b0, 1'b0);
        chk({tag, "_state_updir"}, {28'b0, bus.tap_state}, 32'hD);
        tick(1'b0, 1'b0, 1'b0);
        chk({tag, "_shir_cycles"}, shir_cnt, 32'd4);
        chk({tag, "_instr"}, {28'b0, bus.instruction}, {28'b0, val});
        chk({tag, "_state_rti"}, {28'b0, bus.tap_state}, 32'hC);
        $display("ir_scan %s: shifted %b, instruction now %b", tag, val, bus.instruction);
    endtask

    // Full DR scan of n bits from Run-Test/Idle, ending back in Run-Test/Idle.
    task automatic dr_scan(input logic [3:0] tdis, input logic [3:0] nts, input logic [3:0] exps,
                           input int n, input logic [3:0] instr, input string tag);
        clr_cnt();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk({tag, "_capture"}, {31'b0, bus.capture_dr_o}, 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++)
            shift(i == n - 1, tdis[i], nts[i], exps[i], $sformatf("%s_dr%0d", tag, i));
        tick(1'b1, 1'b0, 1'b0);
        chk({tag, "_update"}, {31'b0, bus.update_dr_o}, 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk({tag, "_cap_cycles"}, cap_cnt, 32'd1);
        chk({tag, "_shdr_cycles"}, shdr_cnt, n);
        chk({tag, "_upd_cycles"}, upd_cnt, 32'd1);
        chk({tag, "_instr"}, {28'b0, bus.instruction}, {28'b0, instr});
        $display("dr_scan %s: %0d bits, instruction %b", tag, n, bus.instruction);
    endtask

    initial begin
        reset = 1'b1;
        bus.tms_pad_in = 1'b0;
        bus.tdi_pad_in = 1'b0;
        bus.next_tdo   = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_state", {28'b0, bus.tap_state}, 32'hF);
        chk("rst_tlr", {31'b0, bus.test_logic_reset_o}, 32'd1);
        chk("rst_instr", {28'b0, bus.instruction}, {28'b0, INST_RESET});
        chk("rst_oe", {31'b0, bus.tdo_pad_oe}, 32'd0);
        chk("rst_tdo", {31'b0, bus.tdo_pad_out}, 32'd0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("rel_state", {28'b0, bus.tap_state}, 32'hC);
        $display("reset: state %h after release", bus.tap_state);

        // Into Shift-DR, then five TMS=1 edges back to Test-Logic-Reset.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("to_shdr", {31'b0, bus.shift_dr_o}, 32'd1);
        begin
            logic [3:0] seq [5];
            seq = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
            for (int i = 0; i < 5; i++) begin
                tick(1'b1, 1'b0, 1'b0);
                chk($sformatf("tms1_walk%0d", i), {28'b0, bus.tap_state}, {28'b0, seq[i]});
            end
        end
        chk("walk_tlr", {31'b0, bus.test_logic_reset_o}, 32'd1);
        chk("walk_instr", {28'b0, bus.instruction}, {28'b0, INST_RESET});
        $display("tms walk: reached state %h", bus.tap_state);

        tick(1'b0, 1'b0, 1'b0);
        ir_scan(4'b0011, "ir1");

        dr_scan(4'b0000, 4'b1001, 4'b1001, 4, 4'b0011, "dr1");

        ir_scan(4'b1111, "ir2");
        dr_scan(4'b0101, 4'b0111, 4'b0010, 3, 4'b1111, "byp");

        // Reset landing in the middle of an IR shift.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        shift(1'b0, 1'b0, 1'b0, INST_RETURN[0], "mid_ir0");
        shift(1'b0, 1'b0, 1'b0, INST_RETURN[1], "mid_ir1");
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_state", {28'b0, bus.tap_state}, 32'hF);
        chk("mid_rst_instr", {28'b0, bus.instruction}, {28'b0, INST_RESET});
        chk("mid_rst_oe", {31'b0, bus.tdo_pad_oe}, 32'd0);
        $display("mid-shift reset: state %h instruction %b", bus.tap_state, bus.instruction);
        tick(1'b0, 1'b0, 1'b0);
        ir_scan(4'b0000, "ir3");

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
